// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory-side bus agent.
package lc3_pkg;

    localparam int LC3_WORD_W          = 16;
    localparam int MEM_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/lc3_mem_timer.sv
// Timeout counter for a pending memory access: clear, load, count-enable,
// and a terminal-count flag raised when the count reaches TERMINAL-1.
module lc3_mem_timer #(
    parameter int TERMINAL = 64,
    parameter int CNT_W    = $clog2(TERMINAL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == CNT_W'(TERMINAL - 1));

    // NOTE: every combinational output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory bus agent: MAR/MDR, req/ack handshake with timeout, the R
// (ready) flag for the control FSM, and the gated MDR driver onto the bus.
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int ADDR_W         = LC3_WORD_W,
    parameter int DATA_W         = LC3_WORD_W,
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_bus,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    input  logic              gate_mdr,
    input  logic              clr_err,
    output logic [DATA_W-1:0] mdr_bus_out,
    output logic              ready,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              timer_clr, timer_en, timer_tc;
    logic              timeout;

    lc3_mem_timer #(
        .TERMINAL (TIMEOUT_CYCLES),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (timer_clr),
        .ld_i     (1'b0),
        .ld_val_i ({CNT_W{1'b0}}),
        .en_i     (timer_en),
        .tc_o     (timer_tc)
    );

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        timer_clr = 1'b1;
        timer_en  = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ld_mar)            mar_d = ADDR_W'(data_bus);
                if (ld_mdr && !mio_en) mdr_d = data_bus;
                if (mio_en)            state_d = r_w ? WR : RD;
            end
            RD, WR: begin
                // MAR/MDR are frozen here; only an acknowledged read updates MDR.
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (mem_ack) begin
                    if (state_q == RD && ld_mdr) mdr_d = mem_rdata;
                    state_d = DONE;
                end else if (timer_tc) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!mio_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        err_d   = (err_q && !clr_err) || timeout;
        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign mem_req     = (state_q == RD) || (state_q == WR);
    assign mem_we      = (state_q == WR);
    assign mem_addr    = mar_q;
    assign mem_wdata   = mdr_q;
    assign ready       = ready_q;
    assign err         = err_q;
    assign mdr_bus_out = gate_mdr ? mdr_q : '0;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Directed bench for lc3_mem_if: reset, read, write, freeze, timeout,
// clear/set race, and reset in the middle of an access.
module tb_lc3_mem_if;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_bus;
    logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr, clr_err;
    logic [15:0] mdr_bus_out;
    logic        ready, err, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int tests  = 0;
    int failed = 0;

    lc3_mem_if #(
        .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_bus    (data_bus),
        .ld_mar      (ld_mar),
        .ld_mdr      (ld_mdr),
        .mio_en      (mio_en),
        .r_w         (r_w),
        .gate_mdr    (gate_mdr),
        .clr_err     (clr_err),
        .mdr_bus_out (mdr_bus_out),
        .ready       (ready),
        .err         (err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle past it before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; data_bus = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
        gate_mdr = 0; clr_err = 0; mem_rdata = '0; mem_ack = 0;
        step(); step();
        rst = 1'b0;
        step();

        check("rst_req",   32'(mem_req), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_err",   32'(err), 32'h0);
        check("rst_bus",   32'(mdr_bus_out), 32'h0);
        check("rst_addr",  32'(mem_addr), 32'h0);

        // Read from x3000, ack on the 3rd request cycle.
        data_bus = 16'h3000; ld_mar = 1;
        step();
        check("rd_mar", 32'(mem_addr), 32'h3000);
        ld_mar = 0; mio_en = 1; r_w = 0; ld_mdr = 1;
        step();
        check("rd_req1",   32'(mem_req), 32'h1);
        check("rd_we1",    32'(mem_we), 32'h0);
        check("rd_ready1", 32'(ready), 32'h0);
        // Freeze: bus loads during the wait are ignored.
        data_bus = 16'h5555; ld_mar = 1;
        step();
        check("frz_addr",  32'(mem_addr), 32'h3000);
        check("frz_mdr",   32'(mem_wdata), 32'h0000);
        check("frz_req",   32'(mem_req), 32'h1);
        ld_mar = 0;
        step();
        check("rd_req3",   32'(mem_req), 32'h1);
        check("rd_ready3", 32'(ready), 32'h0);
        check("rd_addr3", 32'(mem_addr), 32'h3000);
        mem_ack = 1; mem_rdata = 16'h1234;
        step();
        check("rd_ready", 32'(ready), 32'h1);
        check("rd_reqlo", 32'(mem_req), 32'h0);
        check("rd_mdr",   32'(mem_wdata), 32'h1234);
        check("rd_addr",  32'(mem_addr), 32'h3000);
        mem_ack = 0;
        step();
        check("done_hold", 32'(ready), 32'h1);
        gate_mdr = 1;
        #1;
        check("rd_gate", 32'(mdr_bus_out), 32'h1234);
        gate_mdr = 0; mio_en = 0; ld_mdr = 0;
        #1;
        check("rd_ungate", 32'(mdr_bus_out), 32'h0);
        step();
        check("rd_idle", 32'(ready), 32'h0);

        // Write BEEF to x4000, ack on the first request cycle.
        data_bus = 16'h4000; ld_mar = 1;
        step();
        data_bus = 16'hBEEF; ld_mar = 0; ld_mdr = 1;
        step();
        check("wr_mdrld", 32'(mem_wdata), 32'hBEEF);
        ld_mdr = 0; mio_en = 1; r_w = 1;
        step();
        check("wr_req",   32'(mem_req), 32'h1);
        check("wr_we",    32'(mem_we), 32'h1);
        check("wr_wdata", 32'(mem_wdata), 32'hBEEF);
        check("wr_addr",  32'(mem_addr), 32'h4000);
        mem_ack = 1;
        step();
        check("wr_ready", 32'(ready), 32'h1);
        check("wr_reqlo", 32'(mem_req), 32'h0);
        check("wr_welo",  32'(mem_we), 32'h0);
        check("wr_mdr",   32'(mem_wdata), 32'hBEEF);
        mem_ack = 0; mio_en = 0;
        step();
        check("wr_idle", 32'(ready), 32'h0);

        // Timeout: read with no ack.
        mio_en = 1; r_w = 0; ld_mdr = 1;
        step();
        repeat (TO - 1) step();
        check("to_stillreq", 32'(mem_req), 32'h1);
        check("to_noerr",    32'(err), 32'h0);
        check("to_noready",  32'(ready), 32'h0);
        step();
        check("to_err",   32'(err), 32'h1);
        check("to_ready", 32'(ready), 32'h1);
        check("to_reqlo", 32'(mem_req), 32'h0);
        check("to_mdr",   32'(mem_wdata), 32'hBEEF);
        clr_err = 1; mio_en = 0; ld_mdr = 0;
        step();
        check("clr_err", 32'(err), 32'h0);
        clr_err = 0;

        // Timeout coincident with clr_err: set wins.
        mio_en = 1; r_w = 0;
        step();
        repeat (TO - 1) step();
        clr_err = 1;
        step();
        check("race_err", 32'(err), 32'h1);
        clr_err = 0; mio_en = 0;
        step();
        check("sticky_err", 32'(err), 32'h1);
        clr_err = 1;
        step();
        check("clr_err2", 32'(err), 32'h0);
        clr_err = 0;

        // Reset in the 2nd wait cycle of a read, then a stray ack.
        mio_en = 1; r_w = 0; ld_mdr = 1;
        step();
        check("mid_req", 32'(mem_req), 32'h1);
        step();
        rst = 1;
        step();
        check("mid_rst_req",   32'(mem_req), 32'h0);
        check("mid_rst_ready", 32'(ready), 32'h0);
        check("mid_rst_addr",  32'(mem_addr), 32'h0);
        check("mid_rst_mdr",   32'(mem_wdata), 32'h0);
        rst = 0; mio_en = 0; ld_mdr = 0; mem_ack = 1; mem_rdata = 16'hABCD;
        step();
        check("stray_ready", 32'(ready), 32'h0);
        check("stray_mdr",   32'(mem_wdata), 32'h0);
        check("stray_req",   32'(mem_req), 32'h0);
        mem_ack = 0;
        step();
        check("stray_ready2", 32'(ready), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
